// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes, parameter limits
// and counter-width helpers used by the receiver (and a future transmitter).
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK_WAIT
    } uart_state_e;

    localparam logic PAR_MODE_EVEN = 1'b0;
    localparam logic PAR_MODE_ODD  = 1'b1;

    localparam int CLKS_PER_BIT_MIN = 8;
    localparam int CLKS_PER_BIT_MAX = 65535;
    localparam int DATA_BITS_MIN    = 5;
    localparam int DATA_BITS_MAX    = 9;

    function automatic int clk_cnt_w(input int clks_per_bit);
        return $clog2(clks_per_bit);
    endfunction

    function automatic int bit_cnt_w(input int data_bits);
        return $clog2(data_bits + 1);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input; both flops reset to 1 so an
// idle-high line never produces a spurious low after reset.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver with single-entry valid/ready holding register,
// frame/parity error sidebands, overrun and break detection.
// Parity bit and check are compiled in only when UART_RX_PARITY_EN is defined.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 break_det,
    output logic                 busy
);

    localparam int CNT_W  = clk_cnt_w(CLKS_PER_BIT);
    localparam int BCNT_W = bit_cnt_w(DATA_BITS);

    localparam logic [CNT_W-1:0]  HALF_CNT  = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BCNT_W-1:0] DATA_LAST = BCNT_W'(DATA_BITS - 1);
    localparam logic [BCNT_W-1:0] STOP_LAST = BCNT_W'(STOP_BITS - 1);

    generate
        if (CLKS_PER_BIT < CLKS_PER_BIT_MIN || CLKS_PER_BIT > CLKS_PER_BIT_MAX ||
            DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX ||
            (STOP_BITS != 1 && STOP_BITS != 2) ||
            (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_param
            $error("uart_rx_cfg: parameter out of legal range");
        end
    endgenerate

    logic rx_s;

    uart_rx_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (serial_in),
        .sync_out (rx_s)
    );

    uart_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  fe_acc_q, fe_acc_d;
    logic                  pe_acc;
    logic                  par_zero;
    logic                  evt_dlv_q, evt_dlv_d;
    logic                  evt_brk_q, evt_brk_d;

    logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  parity_err_q, parity_err_d;
    logic                  overrun_q, overrun_d;
    logic                  break_det_q, break_det_d;
    logic                  load, accept;

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_SENSE = (PARITY_ODD != 0) ? PAR_MODE_ODD : PAR_MODE_EVEN;
    logic pbit_q, pbit_d;
    logic pe_acc_q, pe_acc_d;

    assign par_zero = ~pbit_q;
    assign pe_acc   = pe_acc_q;
`else
    assign par_zero = 1'b1;
    assign pe_acc   = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bcnt_d    = bcnt_q;
        shift_d   = shift_q;
        fe_acc_d  = fe_acc_q;
        evt_dlv_d = 1'b0;
        evt_brk_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        pbit_d    = pbit_q;
        pe_acc_d  = pe_acc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                bcnt_d   = '0;
                fe_acc_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                pe_acc_d = 1'b0;
`endif
                if (!rx_s) state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == HALF_CNT) state_d = rx_s ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (cnt_q == LAST_CNT) begin
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (bcnt_q == DATA_LAST) begin
                        bcnt_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == LAST_CNT) begin
                    pbit_d   = rx_s;
                    pe_acc_d = ((^shift_q) ^ rx_s) != PAR_SENSE;
                    state_d  = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_q == LAST_CNT) begin
                    // An all-zero frame through the first stop bit is a break, not a word.
                    if (bcnt_q == '0 && !rx_s && shift_q == '0 && par_zero) begin
                        state_d   = ST_BRK_WAIT;
                        evt_brk_d = 1'b1;
                    end else begin
                        fe_acc_d = fe_acc_q | ~rx_s;
                        if (bcnt_q == STOP_LAST) begin
                            state_d   = ST_IDLE;
                            evt_dlv_d = 1'b1;
                        end else begin
                            bcnt_d = bcnt_q + 1'b1;
                        end
                    end
                end
            end
            ST_BRK_WAIT: begin
                if (rx_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d != state_q || state_q == ST_IDLE || state_q == ST_BRK_WAIT) cnt_d = '0;
    end

    // Delivery happens the cycle after the last stop sample, using the staged frame.
    always_comb begin
        load         = evt_dlv_q && (!rx_valid_q || rx_ready);
        accept       = rx_valid_q && rx_ready;
        rx_valid_d   = rx_valid_q;
        rx_data_d    = rx_data_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        overrun_d    = overrun_q;
        break_det_d  = evt_brk_q;
        if (load) begin
            rx_valid_d   = 1'b1;
            rx_data_d    = shift_q;
            frame_err_d  = fe_acc_q;
            parity_err_d = pe_acc;
        end else if (accept) begin
            rx_valid_d = 1'b0;
        end
        if (evt_dlv_q && !load) overrun_d = 1'b1;
        if (accept) overrun_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bcnt_q       <= '0;
            shift_q      <= '0;
            fe_acc_q     <= 1'b0;
            evt_dlv_q    <= 1'b0;
            evt_brk_q    <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
            break_det_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bcnt_q       <= bcnt_d;
            shift_q      <= shift_d;
            fe_acc_q     <= fe_acc_d;
            evt_dlv_q    <= evt_dlv_d;
            evt_brk_q    <= evt_brk_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
            break_det_q  <= break_det_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pbit_q   <= 1'b0;
            pe_acc_q <= 1'b0;
        end else begin
            pbit_q   <= pbit_d;
            pe_acc_q <= pe_acc_d;
        end
    end
`endif

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;
    assign break_det  = break_det_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: two instances (1 and 2 stop bits) checked every cycle
// against a frame-level model driven by the latency formula, plus literal checks.
module tb_uart_rx_cfg;

    localparam int C  = 16;
    localparam int H  = (C - 1) / 2;
    localparam int DA = 8;
    localparam int SA = 1;
    localparam int DB = 7;
    localparam int SB = 2;
`ifdef UART_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int LAT_A = 2 + H + 1 + (DA + P + SA) * C + 1;

    typedef struct packed {
        int         cyc;
        logic       brk;
        logic [8:0] data;
        logic       fe;
        logic       pe;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic line_a = 1'b1, line_b = 1'b1;
    logic rdy_a = 1'b0, rdy_b = 1'b0;
    logic [DA-1:0] data_a;
    logic [DB-1:0] data_b;
    logic valid_a, fe_a, pe_a, ov_a, brk_a, busy_a;
    logic valid_b, fe_b, pe_b, ov_b, brk_b, busy_b;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    ev_t evq0[$];
    ev_t evq1[$];
    bit       m_valid [2];
    bit [8:0] m_data  [2];
    bit       m_fe    [2];
    bit       m_pe    [2];
    bit       m_ov    [2];
    bit       m_brk   [2];

    int rise_cyc_a = 0, fall_cyc_a = 0;
    logic [DA-1:0] rise_data_a = '0;
    logic rise_fe_a = 1'b0;
    logic pv_a = 1'b0;
    int brk_cnt_a = 0;

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(DA), .STOP_BITS(SA), .PARITY_ODD(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .serial_in(line_a), .rx_data(data_a), .rx_valid(valid_a),
        .rx_ready(rdy_a), .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a),
        .break_det(brk_a), .busy(busy_a)
    );

    uart_rx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(DB), .STOP_BITS(SB), .PARITY_ODD(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .serial_in(line_b), .rx_data(data_b), .rx_valid(valid_b),
        .rx_ready(rdy_b), .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b),
        .break_det(brk_b), .busy(busy_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Holding-register behaviour: a frame event either loads, overruns or breaks;
    // otherwise a ready consumer empties the register.
    task automatic model_step(input int d, input bit rdy);
        ev_t e;
        bit  hit;
        hit = 1'b0;
        e   = '0;
        if (d == 0) begin
            if (evq0.size() > 0 && evq0[0].cyc == cyc) begin e = evq0.pop_front(); hit = 1'b1; end
        end else begin
            if (evq1.size() > 0 && evq1[0].cyc == cyc) begin e = evq1.pop_front(); hit = 1'b1; end
        end
        m_brk[d] = hit && e.brk;
        if (hit && !e.brk) begin
            if (!m_valid[d] || rdy) begin
                if (m_valid[d]) m_ov[d] = 1'b0;
                m_valid[d] = 1'b1;
                m_data[d]  = e.data;
                m_fe[d]    = e.fe;
                m_pe[d]    = e.pe;
            end else begin
                m_ov[d] = 1'b1;
            end
        end else if (m_valid[d] && rdy) begin
            m_valid[d] = 1'b0;
            m_ov[d]    = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            evq0.delete();
            evq1.delete();
            for (int i = 0; i < 2; i++) begin
                m_valid[i] = 0; m_data[i] = 0; m_fe[i] = 0; m_pe[i] = 0; m_ov[i] = 0; m_brk[i] = 0;
            end
        end else begin
            model_step(0, rdy_a);
            model_step(1, rdy_b);
        end
    end

    task automatic cmp_dut(input string nm, input int d, input logic v, input logic [8:0] dat,
                           input logic fe, input logic pe, input logic ov, input logic brk);
        chk({nm, ".rx_valid"}, 32'(v), 32'(m_valid[d]));
        if (m_valid[d]) begin
            chk({nm, ".rx_data"}, 32'(dat), 32'(m_data[d]));
            chk({nm, ".frame_err"}, 32'(fe), 32'(m_fe[d]));
            chk({nm, ".parity_err"}, 32'(pe), 32'(m_pe[d]));
        end
        chk({nm, ".overrun"}, 32'(ov), 32'(m_ov[d]));
        chk({nm, ".break_det"}, 32'(brk), 32'(m_brk[d]));
    endtask

    always @(negedge clk) begin
        cmp_dut("a", 0, valid_a, {1'b0, data_a}, fe_a, pe_a, ov_a, brk_a);
        cmp_dut("b", 1, valid_b, {2'b0, data_b}, fe_b, pe_b, ov_b, brk_b);
    end

    always @(negedge clk) begin
        if (valid_a && !pv_a) begin
            rise_cyc_a  = cyc;
            rise_data_a = data_a;
            rise_fe_a   = fe_a;
        end
        if (!valid_a && pv_a) fall_cyc_a = cyc;
        pv_a = valid_a;
        if (brk_a) brk_cnt_a++;
    end

    task automatic set_line(input int d, input logic v);
        if (d == 0) line_a = v;
        else        line_b = v;
    endtask

    task automatic drive_bit(input int d, input logic v);
        set_line(d, v);
        repeat (C) @(negedge clk);
    endtask

    task automatic push_ev(input int d, input ev_t e);
        if (d == 0) evq0.push_back(e);
        else        evq1.push_back(e);
    endtask

    // Called on a negedge; the next posedge is the first one seeing the start bit.
    task automatic send(input int d, input logic [8:0] data, input logic pbit, input logic [1:0] stops);
        int nd, ns, t0;
        logic [8:0] md;
        ev_t e;
        nd = (d == 0) ? DA : DB;
        ns = (d == 0) ? SA : SB;
        md = data & ((9'd1 << nd) - 9'd1);
        t0 = cyc + 1;
        e.data = md;
        e.brk  = (md == 9'd0) && (P == 0 || !pbit) && !stops[0];
        e.cyc  = e.brk ? t0 + 3 + H + (nd + P + 1) * C + 1 : t0 + 3 + H + (nd + P + ns) * C + 1;
        e.fe   = !stops[0] || (ns == 2 && !stops[1]);
        e.pe   = (P == 1) && ((^md) ^ pbit);
        push_ev(d, e);
        drive_bit(d, 1'b0);
        for (int i = 0; i < nd; i++) drive_bit(d, data[i]);
        if (P == 1) drive_bit(d, pbit);
        for (int i = 0; i < ns; i++) drive_bit(d, stops[i]);
        set_line(d, 1'b1);
    endtask

    task automatic hold_break(input int d, input int bit_times);
        int nd, t0;
        ev_t e;
        nd = (d == 0) ? DA : DB;
        t0 = cyc + 1;
        e = '0;
        e.brk = 1'b1;
        e.cyc = t0 + 3 + H + (nd + P + 1) * C + 1;
        push_ev(d, e);
        set_line(d, 1'b0);
        repeat (bit_times * C) @(negedge clk);
        set_line(d, 1'b1);
    endtask

    initial begin
        int t0;
        @(negedge clk);
        chk("reset rx_valid", 32'(valid_a), 0);
        chk("reset rx_data", 32'(data_a), 0);
        chk("reset frame_err", 32'(fe_a), 0);
        chk("reset parity_err", 32'(pe_a), 0);
        chk("reset overrun", 32'(ov_a), 0);
        chk("reset break_det", 32'(brk_a), 0);
        chk("reset busy_a", 32'(busy_a), 0);
        chk("reset busy_b", 32'(busy_b), 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 0xA5 with consumer always ready: one-cycle valid at the formula latency
        rdy_a = 1'b1;
        t0 = cyc + 1;
        send(0, 9'h0A5, 1'b0, 2'b11);
        repeat (20) @(negedge clk);
        chk("a5 latency", 32'(rise_cyc_a - t0), 32'(LAT_A));
        chk("a5 rx_data", 32'(rise_data_a), 32'h0A5);
        chk("a5 frame_err", 32'(rise_fe_a), 0);
        chk("a5 valid width", 32'(fall_cyc_a - rise_cyc_a), 1);
        rdy_a = 1'b0;
        repeat (30) @(negedge clk);

        // 4-cycle start glitch is rejected
        set_line(0, 1'b0);
        repeat (4) @(negedge clk);
        chk("glitch busy high", 32'(busy_a), 1);
        set_line(0, 1'b1);
        repeat (10) @(negedge clk);
        chk("glitch busy low", 32'(busy_a), 0);
        chk("glitch no valid", 32'(valid_a), 0);
        repeat (30) @(negedge clk);

`ifdef UART_RX_PARITY_EN
        // even parity, 0x55 has four ones, parity bit 1 is wrong
        send(1, 9'h055, 1'b1, 2'b11);
        repeat (20) @(negedge clk);
        chk("par rx_valid", 32'(valid_b), 1);
        chk("par rx_data", 32'(data_b), 32'h55);
        chk("par parity_err", 32'(pe_b), 1);
        rdy_b = 1'b1;
        @(negedge clk);
        rdy_b = 1'b0;
        chk("par accept", 32'(valid_b), 0);
        repeat (30) @(negedge clk);
`endif

        // second stop bit low -> frame error
        send(1, 9'h03C, 1'b0, 2'b01);
        repeat (40) @(negedge clk);
        chk("stop2 rx_valid", 32'(valid_b), 1);
        chk("stop2 rx_data", 32'(data_b), 32'h3C);
        chk("stop2 frame_err", 32'(fe_b), 1);
        chk("stop2 parity_err", 32'(pe_b), 0);
        rdy_b = 1'b1;
        @(negedge clk);
        rdy_b = 1'b0;
        repeat (30) @(negedge clk);

        // back-to-back frames with no consumer -> overrun, first word kept
        send(0, 9'h011, 1'b0, 2'b11);
        send(0, 9'h022, 1'b0, 2'b11);
        repeat (20) @(negedge clk);
        chk("ovr rx_valid", 32'(valid_a), 1);
        chk("ovr rx_data", 32'(data_a), 32'h11);
        chk("ovr overrun", 32'(ov_a), 1);
        rdy_a = 1'b1;
        @(negedge clk);
        rdy_a = 1'b0;
        chk("ovr accept valid", 32'(valid_a), 0);
        chk("ovr accept overrun", 32'(ov_a), 0);
        repeat (30) @(negedge clk);

        // break for 20 bit times, then a normal frame
        brk_cnt_a = 0;
        hold_break(0, 20);
        repeat (40) @(negedge clk);
        chk("brk pulses", 32'(brk_cnt_a), 1);
        chk("brk no valid", 32'(valid_a), 0);
        chk("brk busy", 32'(busy_a), 0);
        send(0, 9'h07E, 1'b0, 2'b11);
        repeat (20) @(negedge clk);
        chk("post-brk rx_data", 32'(data_a), 32'h7E);
        chk("post-brk rx_valid", 32'(valid_a), 1);
        rdy_a = 1'b1;
        @(negedge clk);
        rdy_a = 1'b0;
        repeat (30) @(negedge clk);

        // reset in the middle of a frame leaves nothing behind
        set_line(0, 1'b0);
        repeat (40) @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        set_line(0, 1'b1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (300) @(negedge clk);
        chk("rst-mid busy", 32'(busy_a), 0);
        chk("rst-mid valid", 32'(valid_a), 0);
        chk("rst-mid frame_err", 32'(fe_a), 0);

        repeat (10) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
